stacker_core: RTL and testbench
===============================

Name: stacker_core

Overview:
- Parametrised successor of the single-player stacker game engine.
- Owns the board bitmap, the moving block, placement/trim arithmetic, win/lose detection, score and a speed level.
- Sits between the game-pulse divider and the display/VGA board renderer.
- Adds the following:
  - configurable board size and start width;
  - an explicit two-phase placement;
  - a score;
  - speed levels;
  - button restart from WIN/LOSE.

Parameters:
- BOARD_W, 9, board columns (2..16).
- BOARD_H, 10, board rows (2..16).
- START_W, 3, initial block width (1..BOARD_W).
- SPEED_STEP, 3, rows placed per speed_level increment.
- MAX_SPEED, 3, saturation value of speed_level.

Ports:
- master_clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; overrides paused.
- game_pulse  in  1  one-cycle move tick from the external divider.
- btn  in  1  one-cycle debounced, edge-detected drop request.
- paused  in  1  freezes all state except rst.
- state  out  2  0 = PLAY, 1 = WIN, 2 = LOSE.
- block_pos  out  4  leftmost column of the moving block.
- block_width  out  5  current block width.
- block_height  out  5  row the moving block is on.
- board  out  BOARD_W*BOARD_H  row r is board[r*BOARD_W +: BOARD_W]; bit c is column c (0 = left).
- row_placed  out  1  one-cycle pulse when a row is committed.
- score  out  8  total cells kept, saturating at 255.
- speed_level  out  2  consumed by the divider to shorten the game_pulse period.

Behaviour:
- Reset values:
  - state = 0, block_pos = 0, block_width = START_W, block_height = 0;
  - board = 0, score = 0, speed_level = 0, row_placed = 0;
  - dir = right, internal FSM = MOVE.
- Internal FSM states are MOVE, PLACE, WIN, LOSE. The state output is 0 in MOVE and PLACE, 1 in WIN, 2 in LOSE.
- paused = 1:
  - No register changes.
  - Pulses arriving on btn or game_pulse are dropped.
  - row_placed is forced to 0.
- Block mask = ((1 << block_width) - 1) << block_pos. It is always fully inside the board.
- MOVE, on game_pulse:
  - Moving right: if block_pos + block_width == BOARD_W, set dir = left and block_pos - 1; otherwise block_pos + 1.
  - Moving left: if block_pos == 0, set dir = right and block_pos + 1; otherwise block_pos - 1.
  - If block_width == BOARD_W, block_pos stays 0.
- MOVE, on btn: latch the mask and go to PLACE.
  - btn and game_pulse in the same cycle: btn wins and the tick is discarded.
- PLACE (exactly one cycle; btn and game_pulse are ignored):
  - kept = mask if block_height == 0, otherwise mask & row[block_height-1].
  - n = popcount(kept).
  - Write kept into row[block_height] and pulse row_placed.
  - score += n, saturating.
  - If n == 0: go to LOSE. block_height and block_width hold.
  - Else if block_height == BOARD_H-1: go to WIN and set block_width = n.
  - Otherwise:
    - block_height + 1, block_width = n, block_pos = 0, dir = right;
    - go to MOVE.
    - Every SPEED_STEP committed rows, speed_level + 1, saturating at MAX_SPEED.
- WIN/LOSE:
  - game_pulse is ignored.
  - btn performs a soft restart: every register returns to its reset value, and the FSM is back in MOVE the next cycle.
- Latency: btn to board update is 2 cycles (MOVE→PLACE, then commit on the PLACE edge). btn to the new block_height is 2 cycles.
- rst asserted during PLACE: reset takes priority. The row is not committed and row_placed stays 0.
- Arithmetic:
  - block_pos + block_width is computed at 6 bits to avoid overflow.
  - The popcount is BOARD_W-wide, zero-extended to 5 bits.

Decomposition:
- Package stacker_pkg holds:
  - state encodings ST_PLAY/ST_WIN/ST_LOSE;
  - FSM encodings MOVE/PLACE/WIN/LOSE;
  - the score width constant.
- Sub-module stacker_popcount: parametrised in width N, combinational popcount of kept. It is reused by the two-player variant.
- Row select and mask generation stay inline.

Test Plan:
- rst, then btn with no game_pulse: row0 = 0b000000111, block_height = 1, block_width = 3, score = 3, row_placed pulses once, 2 cycles after btn.
- Place row0 at pos 0, then 1 game_pulse and btn: row1 = 0b000000110, block_width = 2, score = 5.
- Block width 3 on a board of width 9, 7 pulses: block_pos sequence 1..6, then 5 (bounce). Then 6 more pulses: ..., 0, 1 (left bounce).
- Row0 at pos 0, row1 dropped at pos 3: n = 0, state = 2, btn there restores all reset values. Also: btn + game_pulse in the same cycle → pos unchanged, placement occurs.
- Perfect stack for 10 rows: state = 1 after the 10th commit, score = 30, speed_level = 3 (saturated).
- Hold paused with btn/game_pulse pulsing: outputs constant. Assert rst during PLACE: board = 0, row_placed = 0.

Source files
------------

// File: rtl/stacker_pkg.sv
// Shared encodings for the stacker game engine: output state codes, FSM states, score width.
package stacker_pkg;

  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_WIN  = 2'd1;
  localparam logic [1:0] ST_LOSE = 2'd2;

  localparam int unsigned SCORE_W = 8;

  typedef enum logic [1:0] {
    MOVE  = 2'd0,
    PLACE = 2'd1,
    WIN   = 2'd2,
    LOSE  = 2'd3
  } fsm_e;

endpackage

// File: rtl/stacker_popcount.sv
// Combinational population count of an N-bit row (N <= 31), result zero-extended to 5 bits.
module stacker_popcount #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] kept,
  output logic [4:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + {4'b0, kept[i]};
    end
  end

endmodule

// File: rtl/stacker_core.sv
// Stacker game engine: moving block, two-phase placement with trimming, win/lose,
// saturating score and speed level, button restart from the end states.
module stacker_core
  import stacker_pkg::*;
#(
  parameter int unsigned BOARD_W    = 9,
  parameter int unsigned BOARD_H    = 10,
  parameter int unsigned START_W    = 3,
  parameter int unsigned SPEED_STEP = 3,
  parameter int unsigned MAX_SPEED  = 3
) (
  input  logic                       master_clk,
  input  logic                       rst,
  input  logic                       game_pulse,
  input  logic                       btn,
  input  logic                       paused,
  output logic [1:0]                 state,
  output logic [3:0]                 block_pos,
  output logic [4:0]                 block_width,
  output logic [4:0]                 block_height,
  output logic [BOARD_W*BOARD_H-1:0] board,
  output logic                       row_placed,
  output logic [SCORE_W-1:0]         score,
  output logic [1:0]                 speed_level
);

  fsm_e                       fsm_q, fsm_d;
  logic [3:0]                 pos_q, pos_d;
  logic [4:0]                 width_q, width_d;
  logic [4:0]                 height_q, height_d;
  logic [BOARD_W*BOARD_H-1:0] board_q, board_d;
  logic [SCORE_W-1:0]         score_q, score_d;
  logic [1:0]                 speed_q, speed_d;
  logic [7:0]                 step_q, step_d;
  logic                       dir_left_q, dir_left_d;
  logic [BOARD_W-1:0]         mask_q, mask_d;
  logic                       placed_q, placed_d;

  logic                       restart;
  logic [5:0]                 pos_end;
  logic [BOARD_W-1:0]         mask;
  logic [BOARD_W-1:0]         prev_row;
  logic [BOARD_W-1:0]         kept;
  logic [4:0]                 n;
  logic [SCORE_W:0]           score_sum;

  assign restart = ((fsm_q == WIN) || (fsm_q == LOSE)) && btn && !paused;

  // State register; a soft restart from WIN/LOSE is indistinguishable from rst.
  always_ff @(posedge master_clk) begin
    if (rst || restart) begin
      fsm_q      <= MOVE;
      pos_q      <= '0;
      width_q    <= 5'(START_W);
      height_q   <= '0;
      board_q    <= '0;
      score_q    <= '0;
      speed_q    <= '0;
      step_q     <= '0;
      dir_left_q <= 1'b0;
      mask_q     <= '0;
      placed_q   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      pos_q      <= pos_d;
      width_q    <= width_d;
      height_q   <= height_d;
      board_q    <= board_d;
      score_q    <= score_d;
      speed_q    <= speed_d;
      step_q     <= step_d;
      dir_left_q <= dir_left_d;
      mask_q     <= mask_d;
      placed_q   <= placed_d;
    end
  end

  assign pos_end = {2'b0, pos_q} + {1'b0, width_q};

  always_comb begin
    mask     = '0;
    prev_row = '0;
    for (int c = 0; c < BOARD_W; c++) begin
      mask[c] = (6'(c) >= {2'b0, pos_q}) && (6'(c) < pos_end);
    end
    for (int r = 0; r < BOARD_H; r++) begin
      if (5'(r) == height_q - 5'd1) prev_row = board_q[r*BOARD_W +: BOARD_W];
    end
  end

  assign kept = (height_q == 5'd0) ? mask_q : (mask_q & prev_row);

  stacker_popcount #(
    .N(BOARD_W)
  ) u_popcount (
    .kept (kept),
    .count(n)
  );

  assign score_sum = {1'b0, score_q} + {{(SCORE_W - 4){1'b0}}, n};

  // Next-state logic; paused leaves everything on hold and drops pulses.
  always_comb begin
    fsm_d      = fsm_q;
    pos_d      = pos_q;
    width_d    = width_q;
    height_d   = height_q;
    board_d    = board_q;
    score_d    = score_q;
    speed_d    = speed_q;
    step_d     = step_q;
    dir_left_d = dir_left_q;
    mask_d     = mask_q;
    placed_d   = 1'b0;
    if (!paused) begin
      unique case (fsm_q)
        MOVE: begin
          if (btn) begin
            mask_d = mask;
            fsm_d  = PLACE;
          end else if (game_pulse) begin
            if (width_q == 5'(BOARD_W)) begin
              pos_d = '0;
            end else if (!dir_left_q) begin
              if (pos_end == 6'(BOARD_W)) begin
                dir_left_d = 1'b1;
                pos_d      = pos_q - 4'd1;
              end else begin
                pos_d = pos_q + 4'd1;
              end
            end else if (pos_q == 4'd0) begin
              dir_left_d = 1'b0;
              pos_d      = 4'd1;
            end else begin
              pos_d = pos_q - 4'd1;
            end
          end
        end
        PLACE: begin
          for (int r = 0; r < BOARD_H; r++) begin
            if (5'(r) == height_q) board_d[r*BOARD_W +: BOARD_W] = kept;
          end
          placed_d = 1'b1;
          score_d  = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
          if (n == 5'd0) begin
            fsm_d = LOSE;
          end else if (height_q == 5'(BOARD_H - 1)) begin
            fsm_d   = WIN;
            width_d = n;
          end else begin
            fsm_d      = MOVE;
            height_d   = height_q + 5'd1;
            width_d    = n;
            pos_d      = '0;
            dir_left_d = 1'b0;
            if (step_q == 8'(SPEED_STEP - 1)) begin
              step_d = '0;
              if (speed_q != 2'(MAX_SPEED)) speed_d = speed_q + 2'd1;
            end else begin
              step_d = step_q + 8'd1;
            end
          end
        end
        WIN, LOSE: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (fsm_q)
      WIN:     state = ST_WIN;
      LOSE:    state = ST_LOSE;
      default: state = ST_PLAY;
    endcase
    row_placed = placed_q && !paused;
  end

  assign block_pos    = pos_q;
  assign block_width  = width_q;
  assign block_height = height_q;
  assign board        = board_q;
  assign score        = score_q;
  assign speed_level  = speed_q;

endmodule

// File: tb/tb_stacker_core.sv
// Directed self-checking bench for stacker_core with default parameters (9x10 board, width 3).
module tb_stacker_core;

  localparam int BW = 9;
  localparam int BH = 10;

  logic             master_clk = 1'b0;
  logic             rst = 1'b0;
  logic             game_pulse = 1'b0;
  logic             btn = 1'b0;
  logic             paused = 1'b0;
  logic [1:0]       state;
  logic [3:0]       block_pos;
  logic [4:0]       block_width;
  logic [4:0]       block_height;
  logic [BW*BH-1:0] board;
  logic             row_placed;
  logic [7:0]       score;
  logic [1:0]       speed_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [BW*BH-1:0] exp_board;
  logic [3:0]       exp_pos [13];

  stacker_core dut (
    .master_clk  (master_clk),
    .rst         (rst),
    .game_pulse  (game_pulse),
    .btn         (btn),
    .paused      (paused),
    .state       (state),
    .block_pos   (block_pos),
    .block_width (block_width),
    .block_height(block_height),
    .board       (board),
    .row_placed  (row_placed),
    .score       (score),
    .speed_level (speed_level)
  );

  always #5 master_clk = ~master_clk;

  task automatic step();
    @(posedge master_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic tick();
    game_pulse = 1'b1;
    step();
    game_pulse = 1'b0;
  endtask

  task automatic drop();
    btn = 1'b1;
    step();
    btn = 1'b0;
    step();
  endtask

  initial begin
    exp_pos = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};

    // Reset values
    do_reset();
    chk("rst_state", 128'(state), 128'd0);
    chk("rst_pos", 128'(block_pos), 128'd0);
    chk("rst_width", 128'(block_width), 128'd3);
    chk("rst_height", 128'(block_height), 128'd0);
    chk("rst_board", 128'(board), 128'd0);
    chk("rst_score", 128'(score), 128'd0);
    chk("rst_speed", 128'(speed_level), 128'd0);
    chk("rst_placed", 128'(row_placed), 128'd0);

    // First drop, no ticks: commit lands two edges after btn
    btn = 1'b1;
    step();
    btn = 1'b0;
    chk("place_no_pulse_yet", 128'(row_placed), 128'd0);
    chk("place_board_not_yet", 128'(board), 128'd0);
    step();
    chk("row0_placed", 128'(row_placed), 128'd1);
    chk("row0_board", 128'(board), 128'h7);
    chk("row0_height", 128'(block_height), 128'd1);
    chk("row0_width", 128'(block_width), 128'd3);
    chk("row0_score", 128'(score), 128'd3);
    step();
    chk("row0_placed_drop", 128'(row_placed), 128'd0);

    // One tick then drop: trimmed to two cells
    tick();
    chk("row1_pos", 128'(block_pos), 128'd1);
    drop();
    chk("row1_board", 128'(board), 128'h7 | (128'h6 << BW));
    chk("row1_width", 128'(block_width), 128'd2);
    chk("row1_score", 128'(score), 128'd5);
    chk("row1_height", 128'(block_height), 128'd2);
    chk("row1_pos_reset", 128'(block_pos), 128'd0);

    // Bounce off both walls
    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("bounce_%0d", i), 128'(block_pos), 128'(exp_pos[i]));
    end

    // Miss entirely -> LOSE, then btn restart
    do_reset();
    drop();
    tick();
    tick();
    tick();
    chk("lose_pos", 128'(block_pos), 128'd3);
    drop();
    chk("lose_state", 128'(state), 128'd2);
    chk("lose_score", 128'(score), 128'd3);
    chk("lose_height", 128'(block_height), 128'd1);
    chk("lose_width", 128'(block_width), 128'd3);
    chk("lose_board", 128'(board), 128'h7);
    chk("lose_placed", 128'(row_placed), 128'd1);
    tick();
    chk("lose_pulse_ignored", 128'(block_pos), 128'd3);
    btn = 1'b1;
    step();
    btn = 1'b0;
    chk("restart_state", 128'(state), 128'd0);
    chk("restart_board", 128'(board), 128'd0);
    chk("restart_score", 128'(score), 128'd0);
    chk("restart_pos", 128'(block_pos), 128'd0);
    chk("restart_height", 128'(block_height), 128'd0);
    chk("restart_width", 128'(block_width), 128'd3);

    // btn and game_pulse together: btn wins
    do_reset();
    tick();
    btn = 1'b1;
    game_pulse = 1'b1;
    step();
    btn = 1'b0;
    game_pulse = 1'b0;
    chk("both_pos_held", 128'(block_pos), 128'd1);
    step();
    chk("both_board", 128'(board), 128'hE);
    chk("both_score", 128'(score), 128'd3);

    // Perfect stack to WIN
    do_reset();
    exp_board = '0;
    for (int r = 0; r < BH; r++) begin
      drop();
      exp_board[r*BW +: BW] = 9'h7;
      if (r == 2) chk("speed_after_3", 128'(speed_level), 128'd1);
      if (r == 5) chk("speed_after_6", 128'(speed_level), 128'd2);
    end
    chk("win_state", 128'(state), 128'd1);
    chk("win_score", 128'(score), 128'd30);
    chk("win_speed", 128'(speed_level), 128'd3);
    chk("win_board", 128'(board), 128'(exp_board));
    chk("win_height", 128'(block_height), 128'd9);
    btn = 1'b1;
    step();
    btn = 1'b0;
    chk("win_restart_state", 128'(state), 128'd0);
    chk("win_restart_speed", 128'(speed_level), 128'd0);

    // Pause freezes everything
    do_reset();
    tick();
    paused = 1'b1;
    for (int i = 0; i < 4; i++) begin
      btn = 1'(i % 2);
      game_pulse = 1'b1;
      step();
      chk($sformatf("pause_pos_%0d", i), 128'(block_pos), 128'd1);
      chk($sformatf("pause_board_%0d", i), 128'(board), 128'd0);
      chk($sformatf("pause_state_%0d", i), 128'(state), 128'd0);
    end
    btn = 1'b0;
    game_pulse = 1'b0;
    paused = 1'b0;
    step();
    chk("unpause_placed", 128'(row_placed), 128'd0);
    tick();
    chk("unpause_pos", 128'(block_pos), 128'd2);
    drop();
    paused = 1'b1;
    #1;
    chk("pause_masks_placed", 128'(row_placed), 128'd0);
    paused = 1'b0;
    step();

    // rst during PLACE wins over the commit
    do_reset();
    btn = 1'b1;
    step();
    btn = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_place_board", 128'(board), 128'd0);
    chk("rst_place_placed", 128'(row_placed), 128'd0);
    chk("rst_place_score", 128'(score), 128'd0);
    step();
    chk("rst_place_board_later", 128'(board), 128'd0);
    chk("rst_place_placed_later", 128'(row_placed), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
